cla_multiword_adder: RTL and testbench
======================================

Name: cla_multiword_adder

Overview:
Sequential wide adder that time-multiplexes one cla_adder16 instance across WORDS 16-bit limbs, LSB limb first. Carry is registered between limbs.
Sits between an operand source and a result consumer, with valid/ready handshakes on both sides.
Lets the design add 16*WORDS-bit operands without replicating the 16-bit CLA datapath.

Parameters:
WORDS, 4, number of 16-bit limbs per operand; legal range 1..16
IDXW, 4, width of limb index counter; must satisfy 2**IDXW >= WORDS

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set presented
in_ready  output  1  block can accept operands; high only in IDLE
a  input  16*WORDS  operand A, limb i = a[16*i+15:16*i]
b  input  16*WORDS  operand B, same limb layout
carry_in  input  1  carry into limb 0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  16*WORDS  registered result
carry_out  output  1  carry out of top limb, registered
busy  output  1  high in RUN or DONE

Behaviour:
- One clock; reset is asynchronous and active-low.
- rst_n low, asynchronously: state=IDLE, idx=0, carry reg=0, operand regs=0, sum=0, carry_out=0, out_valid=0, busy=0, in_ready=1.
- States: IDLE, RUN, DONE. Binary encoding; unused encodings return to IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch a, b; carry reg<=carry_in; idx<=0; go to RUN.
  - sum/carry_out keep their previous values.
- RUN, one limb per cycle:
  - cla_adder16 inputs are limb idx of the latched a and b, plus the carry reg.
  - At the edge: sum limb idx <= adder sum; carry reg <= adder carry_out; idx<=idx+1.
  - When idx==WORDS-1, also carry_out<=adder carry_out and go to DONE.
- DONE:
  - out_valid=1; sum and carry_out held stable.
  - On out_valid&&out_ready at an edge: go to IDLE, out_valid<=0.
  - out_ready low: hold indefinitely.
- Latency: acceptance edge T0, out_valid high after edge T0+WORDS. Minimum accept-to-accept interval is WORDS+2 cycles. No overlap of transactions.
- in_ready = (state==IDLE), combinational from the state register. in_valid outside IDLE is ignored and operands are not sampled.
- Sum is modulo 2**(16*WORDS); overflow is reported only via carry_out.
- Untouched sum limbs during RUN hold their old values. sum is only meaningful while out_valid=1.
- Reset asserted mid-RUN or mid-DONE: transaction is aborted and all outputs go to reset values immediately, with no partial out_valid.
- Simultaneous in_valid with out_ready in DONE: the result is retired and the new operands are not accepted that cycle (in_ready=0).
- WORDS=1: RUN lasts exactly one cycle.

Decomposition:
- Shared include file cla_defs.vh holds:
  - `CLA_LIMB_W 16
  - state encodings `CLA_ST_IDLE 2'd0, `CLA_ST_RUN 2'd1, `CLA_ST_DONE 2'd2
- Sub-module: the existing cla_adder16, instantiated once, purely combinational. Port order: (sum, carry_out, a, b, carry_in).
- Limb select is an indexed part-select on the operand registers; no further sub-modules.
- Gate-count global counters stay valid because cla_adder16 is reused unchanged.

Test Plan:
- WORDS=4, a=64'hFFFF_FFFF_FFFF_FFFF, b=64'h1, carry_in=0 -> sum=64'h0, carry_out=1, out_valid rises exactly 4 cycles after acceptance edge.
- WORDS=4, a=64'h0000_0000_0000_FFFF, b=64'h1, carry_in=0 -> sum=64'h0000_0000_0001_0000, carry_out=0 (carry crosses limb 0->1).
- WORDS=4, a=b=0, carry_in=1 -> sum=64'h1, carry_out=0; WORDS=1, a=b=16'd65535, carry_in=0 -> sum=16'd65534, carry_out=1, latency 1 cycle.
- Backpressure: result ready, out_ready=0 for 3 cycles while in_valid=1 with new operands -> sum/carry_out stable, in_ready=0, new operands not taken. out_ready=1 -> IDLE next edge, then new operands accepted.
- Reset mid-RUN, rst_n low after limb 1 -> out_valid=0, sum=0, carry_out=0, in_ready=1 immediately. Next transaction a=64'h1234, b=64'h1 -> sum=64'h1235.
- Back-to-back: 8 random transactions with out_ready=1 -> each result matches a reference 65-bit sum, and accept-to-accept interval = WORDS+2 cycles.

Source files
------------

// File: rtl/cla_multiword_adder_pkg.sv
// Shared definitions for the multi-word carry-lookahead adder: limb width,
// controller state encoding and the 4-bit lookahead carry helper.
package cla_multiword_adder_pkg;

  localparam int CLA_LIMB_W = 16;

  // Controller states. Only three of the four encodings are used; the
  // controller sends the spare one back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Fully expanded 4-bit lookahead. c[0] is the incoming carry; c[4] is the
  // carry out of the group. When c0 is 0, c[4] is the group generate.
  function automatic logic [4:0] cla_lookahead4(input logic [3:0] g,
                                                input logic [3:0] p,
                                                input logic       c0);
    logic [4:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

endpackage

// File: rtl/cla_adder16.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups, with group
// generate/propagate combined by a second lookahead stage. Purely combinational.
module cla_adder16
  import cla_multiword_adder_pkg::*;
(
  output logic [15:0] sum,
  output logic        carry_out,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_bg;
  logic [3:0]  w_bp;
  logic [4:0]  w_bc;

  // Bit generate/propagate, group lookahead, then per-bit carries and sum.
  always_comb begin
    logic [4:0] t;
    // NOTE: every variable here is assigned before any conditional use, so the
    // block stays purely combinational and no latch is inferred.
    t    = '0;
    w_g  = a & b;
    w_p  = a ^ b;
    w_bg = '0;
    w_bp = '0;
    w_c  = '0;
    for (int k = 0; k < 4; k++) begin
      t       = cla_lookahead4(w_g[4*k +: 4], w_p[4*k +: 4], 1'b0);
      w_bg[k] = t[4];
      w_bp[k] = &w_p[4*k +: 4];
    end
    w_bc = cla_lookahead4(w_bg, w_bp, carry_in);
    for (int k = 0; k < 4; k++) begin
      t              = cla_lookahead4(w_g[4*k +: 4], w_p[4*k +: 4], w_bc[k]);
      w_c[4*k +: 4]  = t[3:0];
    end
    sum       = w_p ^ w_c;
    carry_out = w_bc[4];
  end

endmodule

// File: rtl/cla_multiword_adder.sv
// Sequential wide adder: one cla_adder16 is reused across WORDS limbs, LSB
// limb first, with the inter-limb carry held in a register. Valid/ready
// handshakes on the operand and result sides; one transaction at a time.
module cla_multiword_adder
  import cla_multiword_adder_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int IDXW  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CLA_LIMB_W*WORDS-1:0] a,
  input  logic [CLA_LIMB_W*WORDS-1:0] b,
  input  logic                        carry_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CLA_LIMB_W*WORDS-1:0] sum,
  output logic                        carry_out,
  output logic                        busy
);

  localparam int              W        = CLA_LIMB_W * WORDS;
  localparam int              LIMB_LSB = $clog2(CLA_LIMB_W);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [IDXW-1:0]          r_idx;
  logic                     r_carry;
  logic [W-1:0]             r_a;
  logic [W-1:0]             r_b;
  logic [W-1:0]             r_sum;
  logic                     r_carry_out;

  logic [IDXW+LIMB_LSB-1:0] w_base;
  logic [CLA_LIMB_W-1:0]    w_limb_a;
  logic [CLA_LIMB_W-1:0]    w_limb_b;
  logic [CLA_LIMB_W-1:0]    w_limb_sum;
  logic                     w_limb_cout;
  logic                     w_accept;
  logic                     w_retire;
  logic                     w_last;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign sum       = r_sum;
  assign carry_out = r_carry_out;

  assign w_accept  = in_valid && in_ready;
  assign w_retire  = out_valid && out_ready;
  assign w_last    = (r_idx == LAST_IDX);

  // Bit offset of the current limb; limbs are a power-of-two wide.
  assign w_base    = {r_idx, {LIMB_LSB{1'b0}}};
  assign w_limb_a  = r_a[w_base +: CLA_LIMB_W];
  assign w_limb_b  = r_b[w_base +: CLA_LIMB_W];

  cla_adder16 u_cla_adder16 (
    .sum       (w_limb_sum),
    .carry_out (w_limb_cout),
    .a         (w_limb_a),
    .b         (w_limb_b),
    .carry_in  (r_carry)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: accept in IDLE, one limb per cycle in RUN, hold in DONE.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_RUN;
      ST_RUN:  if (w_last)   w_state_next = ST_DONE;
      ST_DONE: if (w_retire) w_state_next = ST_IDLE;
      default:               w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, per-limb sum write-back and carry chaining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand and result registers are cleared too, so an aborted
      // transaction leaves no stale sum or carry visible after reset.
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= carry_in;
            r_idx   <= '0;
          end
        end
        ST_RUN: begin
          r_sum[w_base +: CLA_LIMB_W] <= w_limb_sum;
          r_carry                     <= w_limb_cout;
          r_idx                       <= r_idx + IDXW'(1);
          if (w_last) r_carry_out <= w_limb_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_multiword_adder.sv
// Scoreboard bench: stimulus pushes reference sums (plain wide arithmetic)
// into queues; per-DUT monitors pop and compare on each result handshake.
module tb_cla_multiword_adder;

  localparam int WORDS = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // WORDS=4 instance
  logic        in_valid, in_ready, carry_in, out_valid, out_ready, carry_out, busy;
  logic [63:0] a, b, sum;
  // WORDS=1 instance
  logic        d1_in_valid, d1_in_ready, d1_carry_in, d1_out_valid, d1_out_ready;
  logic        d1_carry_out, d1_busy;
  logic [15:0] d1_a, d1_b, d1_sum;

  logic [64:0] exp_q[$];
  logic [16:0] exp1_q[$];

  cla_multiword_adder #(.WORDS(WORDS), .IDXW(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry_out(carry_out), .busy(busy)
  );

  cla_multiword_adder #(.WORDS(1), .IDXW(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .a(d1_a), .b(d1_b), .carry_in(d1_carry_in), .out_valid(d1_out_valid),
    .out_ready(d1_out_ready), .sum(d1_sum), .carry_out(d1_carry_out), .busy(d1_busy)
  );

  function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic c);
    return {1'b0, x} + {1'b0, y} + 65'(c);
  endfunction

  function automatic logic [16:0] ref_add1(input logic [15:0] x, input logic [15:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + 17'(c);
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Result monitors: one comparison per completed output handshake.
  always @(negedge clk) begin
    logic [64:0] e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut4_unexpected_result: got %h expected none", {carry_out, sum});
      end else begin
        e = exp_q.pop_front();
        check("dut4_result", {carry_out, sum}, e);
      end
    end
  end

  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n === 1'b1 && d1_out_valid === 1'b1 && d1_out_ready === 1'b1) begin
      if (exp1_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1_unexpected_result: got %h expected none", {d1_carry_out, d1_sum});
      end else begin
        e = exp1_q.pop_front();
        check("dut1_result", 65'({d1_carry_out, d1_sum}), 65'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send4(input logic [63:0] av, input logic [63:0] bv, input logic cv,
                       input bit chk_lat, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("dut4_in_ready_wait", 65'(in_ready), 65'd1);
    a        = av;
    b        = bv;
    carry_in = cv;
    in_valid = 1'b1;
    exp_q.push_back(ref_add(av, bv, cv));
    @(posedge clk);
    #1 in_valid = 1'b0;
    acc_cyc = cyc;
    if (chk_lat) begin
      n = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("dut4_latency", 65'(n), 65'(WORDS));
    end
  endtask

  task automatic send1(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    int n;
    n = 0;
    @(negedge clk);
    while (d1_in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("dut1_in_ready_wait", 65'(d1_in_ready), 65'd1);
    d1_a        = av;
    d1_b        = bv;
    d1_carry_in = cv;
    d1_in_valid = 1'b1;
    exp1_q.push_back(ref_add1(av, bv, cv));
    @(posedge clk);
    #1 d1_in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (d1_out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("dut1_latency", 65'(n), 65'd1);
  endtask

  initial begin
    int          t_acc, t_prev;
    int          n;
    logic [63:0] ra, rb;
    logic        rc;
    logic [64:0] exp_hold;

    rst_n       = 1'b0;
    in_valid    = 1'b0;  a = '0;  b = '0;  carry_in = 1'b0;  out_ready = 1'b1;
    d1_in_valid = 1'b0;  d1_a = '0;  d1_b = '0;  d1_carry_in = 1'b0;  d1_out_ready = 1'b1;

    // Reset state
    #1;
    check("rst_in_ready",  65'(in_ready),  65'd1);
    check("rst_out_valid", 65'(out_valid), 65'd0);
    check("rst_busy",      65'(busy),      65'd0);
    check("rst_result",    {carry_out, sum}, 65'd0);
    check("rst_d1_ready",  65'(d1_in_ready), 65'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed carry-propagation cases
    send4(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, t_acc);
    send4(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b1, t_acc);
    send4(64'h0, 64'h0, 1'b1, 1'b1, t_acc);

    // Backpressure: result held, new operands offered but ignored
    @(negedge clk);
    while (in_ready !== 1'b1) @(negedge clk);
    out_ready = 1'b0;
    send4(64'hDEAD_BEEF_0123_4567, 64'h8000_0000_FFFF_0001, 1'b1, 1'b1, t_acc);
    exp_hold = ref_add(64'hDEAD_BEEF_0123_4567, 64'h8000_0000_FFFF_0001, 1'b1);
    a        = 64'h5555_5555_5555_5555;
    b        = 64'hAAAA_AAAA_AAAA_AAAA;
    carry_in = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_out_valid", 65'(out_valid), 65'd1);
      check("bp_in_ready",  65'(in_ready),  65'd0);
      check("bp_hold",      {carry_out, sum}, exp_hold);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_after_retire", 65'(in_ready), 65'd1);
    check("bp_busy_after_retire", 65'(busy),     65'd0);
    exp_q.push_back(ref_add(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1));
    @(posedge clk);
    #1 in_valid = 1'b0;

    // Reset in the middle of RUN, after two limbs
    send4(64'h1111_2222_FFFF_FFFF, 64'h1, 1'b0, 1'b0, t_acc);
    @(negedge clk);
    check("run_busy",     65'(busy),     65'd1);
    check("run_in_ready", 65'(in_ready), 65'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 65'(out_valid), 65'd0);
    check("midrst_in_ready",  65'(in_ready),  65'd1);
    check("midrst_busy",      65'(busy),      65'd0);
    check("midrst_result",    {carry_out, sum}, 65'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send4(64'h1234, 64'h1, 1'b0, 1'b1, t_acc);

    // Back-to-back random transactions with accept-to-accept interval
    t_prev = 0;
    for (int i = 0; i < 8; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      rc = 1'($urandom_range(0, 1));
      if (i == 0) begin
        rb = ~ra;
        rc = 1'b1;
      end
      send4(ra, rb, rc, 1'b0, t_acc);
      if (i > 0) check("b2b_interval", 65'(t_acc - t_prev), 65'(WORDS + 2));
      t_prev = t_acc;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("dut4_drained", 65'(exp_q.size()), 65'd0);

    // Single-limb instance
    send1(16'hFFFF, 16'hFFFF, 1'b0);
    send1(16'h0000, 16'h0000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      send1(16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)));
    end
    n = 0;
    while (exp1_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("dut1_drained", 65'(exp1_q.size()), 65'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
